// File: rtl/mem_stage.sv
// Memory-access stage: one bus read/write per instruction with wait states,
// byte-lane alignment, and misaligned/illegal/timeout detection.
module mem_stage #(
  parameter int WAIT_LIMIT = 64,
  parameter int CNT_W      = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        hb,
  input  logic        lb,
  input  logic [15:0] alu_result_in,
  input  logic [15:0] store_data_in,
  input  logic        wb_en_in,
  input  logic [2:0]  dest_reg_in,
  input  logic [15:0] pc_in,
  output logic [15:0] mem_addr_o,
  output logic        mem_re_o,
  output logic        mem_we_o,
  output logic [1:0]  mem_be_o,
  output logic [15:0] mem_data_o,
  input  logic [15:0] mem_data_i,
  input  logic        need_wait_i,
  output logic        busy,
  output logic        done,
  output logic        rf_we,
  output logic        rf_hb,
  output logic        rf_lb,
  output logic [2:0]  rf_dest,
  output logic [15:0] rf_data,
  output logic [15:0] pc_out,
  output logic        misaligned,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic             r_load;
  logic             r_store;
  logic             r_word;
  logic [15:0]      r_addr;
  logic [15:0]      r_sd;
  logic [CNT_W-1:0] r_cnt;

  logic w_accept;
  logic w_mem;
  logic w_word;
  logic w_illegal;
  logic w_misal;
  logic w_acc;
  logic w_ok;
  logic w_timeout;

  assign w_accept  = (r_state == S_IDLE) && en;
  assign w_mem     = is_load | is_store;
  // no lane enables on a memory op means a full word
  assign w_word    = ~(hb ^ lb);
  assign w_illegal = is_load & is_store;
  assign w_misal   = w_mem & ~w_illegal & w_word & alu_result_in[0];
  assign w_acc     = (r_state == S_ACCESS);
  assign w_ok      = w_acc && !need_wait_i;
  assign w_timeout = w_acc && need_wait_i &&
                     (r_cnt == CNT_W'(WAIT_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (en) begin
          if (!w_mem || w_illegal || w_misal) w_next = S_RESP;
          else                                w_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (w_ok || w_timeout) w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_re_o   = w_acc & r_load;
    mem_we_o   = w_acc & r_store;
    mem_addr_o = w_acc ? {r_addr[15:1], 1'b0} : 16'h0000;
    mem_be_o   = 2'b00;
    mem_data_o = 16'h0000;
    if (w_acc) begin
      if (r_word)         mem_be_o = 2'b11;
      else if (r_addr[0]) mem_be_o = 2'b10;
      else                mem_be_o = 2'b01;
    end
    if (w_acc && r_store) begin
      mem_data_o = r_word ? r_sd : {r_sd[7:0], r_sd[7:0]};
    end
    busy = (r_state != S_IDLE);
    done = (r_state == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_load     <= 1'b0;
      r_store    <= 1'b0;
      r_word     <= 1'b0;
      r_addr     <= 16'h0000;
      r_sd       <= 16'h0000;
      r_cnt      <= '0;
      rf_we      <= 1'b0;
      rf_hb      <= 1'b0;
      rf_lb      <= 1'b0;
      rf_dest    <= 3'd0;
      rf_data    <= 16'h0000;
      pc_out     <= 16'h0000;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
    end else if (w_accept) begin
      r_load     <= is_load;
      r_store    <= is_store;
      r_word     <= w_word;
      r_addr     <= alu_result_in;
      r_sd       <= store_data_in;
      r_cnt      <= '0;
      rf_dest    <= dest_reg_in;
      pc_out     <= pc_in;
      misaligned <= w_misal;
      bus_err    <= w_illegal;
      if (!w_mem) begin
        rf_we   <= wb_en_in;
        rf_data <= alu_result_in;
        rf_hb   <= hb;
        rf_lb   <= lb;
      end else begin
        rf_we   <= 1'b0;
        rf_data <= 16'h0000;
        rf_hb   <= 1'b0;
        rf_lb   <= 1'b0;
      end
    end else if (w_acc) begin
      if (need_wait_i) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_timeout) bus_err <= 1'b1;
      end else if (r_load) begin
        rf_we <= 1'b1;
        rf_hb <= 1'b1;
        rf_lb <= 1'b1;
        if (r_word)         rf_data <= mem_data_i;
        else if (r_addr[0]) rf_data <= {8'h00, mem_data_i[15:8]};
        else                rf_data <= {8'h00, mem_data_i[7:0]};
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores, errors,
// timeout, reset mid-access and en while busy.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        is_load;
  logic        is_store;
  logic        hb;
  logic        lb;
  logic [15:0] alu_result_in;
  logic [15:0] store_data_in;
  logic        wb_en_in;
  logic [2:0]  dest_reg_in;
  logic [15:0] pc_in;
  logic [15:0] mem_addr_o;
  logic        mem_re_o;
  logic        mem_we_o;
  logic [1:0]  mem_be_o;
  logic [15:0] mem_data_o;
  logic [15:0] mem_data_i;
  logic        need_wait_i;
  logic        busy;
  logic        done;
  logic        rf_we;
  logic        rf_hb;
  logic        rf_lb;
  logic [2:0]  rf_dest;
  logic [15:0] rf_data;
  logic [15:0] pc_out;
  logic        misaligned;
  logic        bus_err;

  int checks   = 0;
  int failures = 0;
  int n_re;
  int n_done;
  logic       seen_done;
  logic       seen_err;
  logic       seen_we;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .en(en),
    .is_load(is_load), .is_store(is_store),
    .hb(hb), .lb(lb),
    .alu_result_in(alu_result_in),
    .store_data_in(store_data_in),
    .wb_en_in(wb_en_in), .dest_reg_in(dest_reg_in),
    .pc_in(pc_in),
    .mem_addr_o(mem_addr_o), .mem_re_o(mem_re_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .need_wait_i(need_wait_i),
    .busy(busy), .done(done),
    .rf_we(rf_we), .rf_hb(rf_hb), .rf_lb(rf_lb),
    .rf_dest(rf_dest), .rf_data(rf_data),
    .pc_out(pc_out),
    .misaligned(misaligned), .bus_err(bus_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic ld, input logic st,
                    input logic h, input logic l,
                    input logic [15:0] a, input logic [15:0] sd);
    en            = 1'b1;
    is_load       = ld;
    is_store      = st;
    hb            = h;
    lb            = l;
    alu_result_in = a;
    store_data_in = sd;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; is_load = 1'b0; is_store = 1'b0;
    hb = 1'b0; lb = 1'b0; alu_result_in = 16'h0; store_data_in = 16'h0;
    wb_en_in = 1'b0; dest_reg_in = 3'd0; pc_in = 16'h0;
    mem_data_i = 16'h0; need_wait_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rfwe", rf_we, 0);
    chk("rst_rfdata", rf_data, 0);
    chk("rst_re", mem_re_o, 0);
    rst = 1'b0;

    // pass-through
    op(0, 0, 1, 1, 16'h1234, 16'h0);
    wb_en_in = 1'b1; dest_reg_in = 3'd3; pc_in = 16'h0100;
    @(negedge clk);
    en = 1'b0;
    chk("pt_done", done, 1);
    chk("pt_rfwe", rf_we, 1);
    chk("pt_data", rf_data, 16'h1234);
    chk("pt_dest", rf_dest, 3);
    chk("pt_pc", pc_out, 16'h0100);
    chk("pt_strobe", {mem_re_o, mem_we_o}, 0);
    @(negedge clk);
    chk("pt_done_pulse", done, 0);
    chk("pt_idle", busy, 0);

    // word load, zero wait
    op(1, 0, 1, 1, 16'h0040, 16'h0);
    dest_reg_in = 3'd5; mem_data_i = 16'hBEEF;
    @(negedge clk);
    en = 1'b0;
    chk("wl_re", mem_re_o, 1);
    chk("wl_addr", mem_addr_o, 16'h0040);
    chk("wl_be", mem_be_o, 2'b11);
    chk("wl_done_early", done, 0);
    @(negedge clk);
    chk("wl_done", done, 1);
    chk("wl_re_off", mem_re_o, 0);
    chk("wl_data", rf_data, 16'hBEEF);
    chk("wl_rfwe", rf_we, 1);
    @(negedge clk);

    // byte load high lane, three wait cycles
    op(1, 0, 0, 1, 16'h0041, 16'h0);
    mem_data_i = 16'hA55A; need_wait_i = 1'b1;
    @(negedge clk);
    en = 1'b0;
    n_re = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_re_o && mem_addr_o == 16'h0040 && !done) n_re++;
      if (i == 3) need_wait_i = 1'b0;
      if (i < 3) @(negedge clk);
    end
    chk("bl_re_cycles", n_re, 4);
    chk("bl_be", mem_be_o, 2'b10);
    @(negedge clk);
    chk("bl_done", done, 1);
    chk("bl_data", rf_data, 16'h00A5);
    chk("bl_lanes", {rf_hb, rf_lb}, 2'b11);
    @(negedge clk);

    // byte store high lane
    op(0, 1, 0, 1, 16'h0011, 16'h7712);
    @(negedge clk);
    en = 1'b0;
    chk("bs_we", mem_we_o, 1);
    chk("bs_re", mem_re_o, 0);
    chk("bs_be", mem_be_o, 2'b10);
    chk("bs_wdata", mem_data_o, 16'h1212);
    chk("bs_addr", mem_addr_o, 16'h0010);
    @(negedge clk);
    chk("bs_done", done, 1);
    chk("bs_rfwe", rf_we, 0);
    chk("bs_we_off", mem_we_o, 0);
    @(negedge clk);

    // misaligned word load
    op(1, 0, 1, 1, 16'h0003, 16'h0);
    @(negedge clk);
    en = 1'b0;
    chk("mis_flag", misaligned, 1);
    chk("mis_done", done, 1);
    chk("mis_re", mem_re_o, 0);
    chk("mis_rfwe", rf_we, 0);
    @(negedge clk);

    // illegal load+store
    op(1, 1, 1, 1, 16'h0020, 16'h0);
    @(negedge clk);
    en = 1'b0;
    chk("ill_err", bus_err, 1);
    chk("ill_mis_clr", misaligned, 0);
    chk("ill_done", done, 1);
    chk("ill_strobe", {mem_re_o, mem_we_o}, 0);
    @(negedge clk);

    // timeout with need_wait stuck high
    op(1, 0, 1, 1, 16'h0020, 16'h0);
    need_wait_i = 1'b1;
    @(negedge clk);
    en = 1'b0;
    n_re = 0; seen_done = 1'b0; seen_err = 1'b0; seen_we = 1'b1;
    for (int i = 0; i < 70 && !seen_done; i++) begin
      if (mem_re_o) n_re++;
      if (done) begin
        seen_done = 1'b1;
        seen_err  = bus_err;
        seen_we   = rf_we;
      end
      @(negedge clk);
    end
    chk("to_re_cycles", n_re, 64);
    chk("to_done", seen_done, 1);
    chk("to_err", seen_err, 1);
    chk("to_rfwe", seen_we, 0);
    need_wait_i = 1'b0;

    // reset during access
    op(1, 0, 1, 1, 16'h0040, 16'h0);
    need_wait_i = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("rma_re", mem_re_o, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rma_re_off", mem_re_o, 0);
    chk("rma_busy", busy, 0);
    chk("rma_done", done, 0);
    rst = 1'b0; need_wait_i = 1'b0;
    @(negedge clk);
    chk("rma_no_done", done, 0);

    // en while busy is ignored
    op(0, 1, 1, 1, 16'h0050, 16'hABCD);
    need_wait_i = 1'b1;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    op(0, 1, 1, 1, 16'h0060, 16'h1111);
    @(negedge clk);
    en = 1'b0;
    chk("eb_addr", mem_addr_o, 16'h0050);
    chk("eb_wdata", mem_data_o, 16'hABCD);
    need_wait_i = 1'b0;
    n_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("eb_single_done", n_done, 1);
    chk("eb_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
